// File: rtl/shift_add_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : shift_add_mult_ctrl                                          |
// | Description : Sequential unsigned M x N shift-and-add multiplier           |
// |               controller. It time-shares one external 64-bit              |
// |               combinational adder, retiring one multiplier bit per clock.  |
// |               Operands enter and the product leaves through valid/ready    |
// |               handshakes.                                                  |
// | Ports       : clk, rst       - clock, asynchronous active-high reset       |
// |               in_valid/ready - operand handshake (in_a x in_b)             |
// |               out_valid/ready- product handshake, product zero-extended    |
// |               busy           - high while a job is running or waiting      |
// |               add_a/b, add_o - external adder operands and its sum         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module shift_add_mult_ctrl #(
   parameter int M_WIDTH    = 32,
   parameter int N_WIDTH    = 32,
   parameter int EARLY_EXIT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [M_WIDTH-1:0] in_a,
   input  logic [N_WIDTH-1:0] in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [63:0]        product,
   output logic               busy,
   output logic [63:0]        add_a,
   output logic [63:0]        add_b,
   input  logic [63:0]        add_o
);

   // Parameter legality is checked at elaboration: the product must fit the
   // 64-bit adder so its missing carry-out never matters.
   if ((M_WIDTH + N_WIDTH > 64) || (N_WIDTH < 1) || (M_WIDTH < 1)) begin : g_bad_params
      $error("shift_add_mult_ctrl: illegal M_WIDTH/N_WIDTH combination");
   end

   localparam int CNT_W = $clog2(N_WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(N_WIDTH - 1);
   localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

   logic [1:0]         state_q, state_d;
   logic [63:0]        acc_q,   acc_d;
   logic [63:0]        a_reg_q, a_reg_d;
   logic [N_WIDTH-1:0] b_reg_q, b_reg_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;

   logic w_run;
   logic w_early_done;

   assign w_run = (state_q == S_RUN);

   // With early exit, once every remaining multiplier bit is zero the
   // accumulator already holds the final product.
   assign w_early_done = (EARLY_EXIT != 0) && (b_reg_q == '0);

   // Adder drive: accumulate the shifted multiplicand only when the current
   // multiplier bit is set; idle the adder at zero outside RUN.
   assign add_a = w_run ? acc_q : 64'd0;
   assign add_b = (w_run && b_reg_q[0]) ? a_reg_q : 64'd0;

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign product   = acc_q;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      a_reg_d = a_reg_q;
      b_reg_d = b_reg_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_reg_d = 64'(in_a);
               b_reg_d = in_b;
               acc_d   = 64'd0;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (w_early_done) begin
               state_d = S_DONE;
            end else begin
               acc_d   = add_o;
               a_reg_d = a_reg_q << 1;
               b_reg_d = b_reg_q >> 1;
               cnt_d   = cnt_q + C_CNT_ONE;
               // The comparison uses the count before increment: the last
               // multiplier bit is being retired on this edge.
               if (cnt_q == C_LAST_CNT) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= 64'd0;
         a_reg_q <= 64'd0;
         b_reg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         a_reg_q <= a_reg_d;
         b_reg_q <= b_reg_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_shift_add_mult_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_shift_add_mult_ctrl                                       |
// | Description : Scoreboard bench for shift_add_mult_ctrl. Two instances:     |
// |               dut0 with EARLY_EXIT=0, dut1 with EARLY_EXIT=1, each with    |
// |               its own 64-bit adder model.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_shift_add_mult_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid_v  [2];
   logic        in_ready_v  [2];
   logic        out_valid_v [2];
   logic        out_ready_v [2];
   logic        busy_v      [2];
   logic [31:0] in_a_v      [2];
   logic [31:0] in_b_v      [2];
   logic [63:0] product_v   [2];
   logic [63:0] add_a_v     [2];
   logic [63:0] add_b_v     [2];
   logic [63:0] add_o_v     [2];

   // External adder: plain 64-bit sum, carry-out discarded.
   assign add_o_v[0] = add_a_v[0] + add_b_v[0];
   assign add_o_v[1] = add_a_v[1] + add_b_v[1];

   shift_add_mult_ctrl #(.M_WIDTH(32), .N_WIDTH(32), .EARLY_EXIT(0)) u_dut0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
      .in_a(in_a_v[0]), .in_b(in_b_v[0]),
      .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
      .product(product_v[0]), .busy(busy_v[0]),
      .add_a(add_a_v[0]), .add_b(add_b_v[0]), .add_o(add_o_v[0])
   );

   shift_add_mult_ctrl #(.M_WIDTH(32), .N_WIDTH(32), .EARLY_EXIT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
      .in_a(in_a_v[1]), .in_b(in_b_v[1]),
      .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
      .product(product_v[1]), .busy(busy_v[1]),
      .add_a(add_a_v[1]), .add_b(add_b_v[1]), .add_o(add_o_v[1])
   );

   typedef struct {
      int          k;
      logic [63:0] prod;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Reference latency from the operand values alone.
   function automatic int exp_lat(input bit early, input logic [31:0] b);
      int m;
      if (!early) return 32;
      if (b == 32'd0) return 1;
      m = 0;
      for (int i = 0; i < 32; i++) if (b[i]) m = i;
      return (m + 2 < 32) ? m + 2 : 32;
   endfunction

   // Inputs change 1 ns after the falling edge; the monitor samples 2 ns after.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic send(input int k, input logic [31:0] a, input logic [31:0] b);
      int   g;
      exp_t e;
      step();
      in_valid_v[k] = 1'b1;
      in_a_v[k]     = a;
      in_b_v[k]     = b;
      g = 0;
      while (!in_ready_v[k] && g < 200) begin
         step();
         g++;
      end
      if (!in_ready_v[k]) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout dut%0d: in_ready=0, required 1", k);
         return;
      end
      e.k       = k;
      e.prod    = 64'(a) * 64'(b);
      e.lat     = exp_lat(k == 1, b);
      e.acc_cyc = cyc;
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic wait_done(input int k, input bit rnd);
      int g;
      bit done;
      g    = 0;
      done = 1'b0;
      while (!done && g < 200) begin
         step();
         in_valid_v[k]  = 1'b0;
         out_ready_v[k] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid_v[k] && out_ready_v[k]) done = 1'b1;
         g++;
      end
      if (!done) begin
         n_vec++;
         n_err++;
         $display("FAIL done_timeout dut%0d: out_valid=%0b, required 1", k, out_valid_v[k]);
      end
      @(posedge clk);
   endtask

   task automatic chk_reset_outputs(input int k, input string tag);
      chk({tag, "_in_ready"},  64'(in_ready_v[k]),  64'd1);
      chk({tag, "_out_valid"}, 64'(out_valid_v[k]), 64'd0);
      chk({tag, "_busy"},      64'(busy_v[k]),      64'd0);
      chk({tag, "_product"},   product_v[k],        64'd0);
      chk({tag, "_add_a"},     add_a_v[k],          64'd0);
      chk({tag, "_add_b"},     add_b_v[k],          64'd0);
   endtask

   // ---------------------------------------------------------------- monitor
   bit          prev_ov  [2];
   bit          post_hs  [2];
   logic [63:0] hold_prod[2];

   initial begin
      prev_ov   = '{0, 0};
      post_hs   = '{0, 0};
      hold_prod = '{64'd0, 64'd0};
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            prev_ov = '{0, 0};
            post_hs = '{0, 0};
         end else begin
            for (int k = 0; k < 2; k++) begin
               if (post_hs[k]) begin
                  chk("out_valid_after_handshake", 64'(out_valid_v[k]), 64'd0);
                  chk("in_ready_after_handshake",  64'(in_ready_v[k]),  64'd1);
                  post_hs[k] = 1'b0;
               end
               if (out_valid_v[k]) begin
                  if (!prev_ov[k]) begin
                     int idx;
                     idx = -1;
                     foreach (sb[i]) if (idx < 0 && sb[i].k == k) idx = i;
                     if (idx < 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_valid dut%0d: out_valid=1 with no job pending", k);
                     end else begin
                        chk("product", product_v[k], sb[idx].prod);
                        chk("latency", 64'(cyc - sb[idx].acc_cyc - 1), 64'(sb[idx].lat));
                        chk("busy_in_done", 64'(busy_v[k]), 64'd1);
                        sb.delete(idx);
                     end
                     hold_prod[k] = product_v[k];
                  end else begin
                     chk("product_hold",     product_v[k],        hold_prod[k]);
                     chk("in_ready_in_done", 64'(in_ready_v[k]),  64'd0);
                  end
                  if (out_ready_v[k]) post_hs[k] = 1'b1;
               end
               prev_ov[k] = out_valid_v[k] && !out_ready_v[k];
            end
         end
      end
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [31:0] ra, rb;
      int          g;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         in_valid_v[k]  = 1'b0;
         in_a_v[k]      = 32'd0;
         in_b_v[k]      = 32'd0;
         out_ready_v[k] = 1'b1;
      end
      step();
      step();
      chk_reset_outputs(0, "reset0");
      chk_reset_outputs(1, "reset1");
      rst = 1'b0;

      // Full-width operands, no early exit.
      send(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(0, 1'b0);

      // Early exit latencies.
      send(1, 32'd7, 32'd5);
      wait_done(1, 1'b0);
      send(1, 32'd7, 32'd0);
      wait_done(1, 1'b0);
      send(1, 32'd7, 32'h8000_0000);
      wait_done(1, 1'b0);

      // Backpressure: hold the result for 10 cycles.
      out_ready_v[0] = 1'b0;
      send(0, 32'h1234_5678, 32'h10);
      g = 0;
      step();
      in_valid_v[0] = 1'b0;
      while (!out_valid_v[0] && g < 100) begin
         step();
         g++;
      end
      chk("backpressure_valid_seen", 64'(out_valid_v[0]), 64'd1);
      repeat (10) step();
      step();
      out_ready_v[0] = 1'b1;
      @(posedge clk);

      // in_valid held across RUN with changed operands.
      send(0, 32'd2, 32'd3);
      send(0, 32'd4, 32'd5);
      wait_done(0, 1'b0);

      // Adder drive sequence over the first four RUN cycles.
      send(0, 32'd3, 32'b1010);
      for (int c = 1; c <= 4; c++) begin
         logic [31:0] low_mask;
         step();
         in_valid_v[0] = 1'b0;
         low_mask = (32'd1 << (c - 1)) - 32'd1;
         chk("adder_a", add_a_v[0], 64'd3 * 64'(32'b1010 & low_mask));
         chk("adder_b", add_b_v[0], ((32'b1010 >> (c - 1)) & 32'd1) != 0 ? (64'd3 << (c - 1)) : 64'd0);
      end
      wait_done(0, 1'b0);

      // Asynchronous reset in the middle of a job.
      send(0, 32'hDEAD_BEEF, 32'hF00D_CAFE);
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      in_valid_v[0] = 1'b0;
      #1;
      chk_reset_outputs(0, "midrun_reset");
      sb.delete();
      step();
      step();
      rst = 1'b0;
      send(0, 32'd1234567, 32'd89);
      wait_done(0, 1'b0);

      // Randomized jobs with random consumer backpressure.
      for (int j = 0; j < 12; j++) begin
         for (int k = 0; k < 2; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            send(k, ra, rb);
            wait_done(k, 1'b1);
         end
      end

      step();
      step();
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
